conv1_ofmap_streamer: RTL and testbench

// - Drains the conv1 output feature map (27x27x96, 16-bit, post-ReLU) from its on-chip buffer.
// - Emits the map as a valid/ready stream tagged with row/col/channel, plus an end-of-frame marker.
// - Sits on the consumer side of the conv1 output buffer: it is the reader to the conv1 engine's writer.
// - Feeds the next layer or the host; a 32-bit checksum is produced for bench self-checking.

---
 rtl/conv1_pkg.sv | 38 +++
 rtl/conv1_skid_fifo.sv | 39 +++
 rtl/conv1_ofmap_streamer.sv | 107 ++++++++++
 tb/tb_conv1_ofmap_streamer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// Shared conv1 types: feature-map geometry, stream tags and streamer FSM states.
package conv1_pkg;

  localparam int C1_OUT_H = 27;
  localparam int C1_OUT_W = 27;
  localparam int C1_OUT_C = 96;
  localparam int C1_DW    = 16;

  typedef logic [15:0] c1_feat_t;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [6:0] ch;
  } c1_tag_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} c1_strm_state_e;

  // Raster order with channel fastest; the row saturates at the last row.
  function automatic c1_tag_t c1_tag_next(input c1_tag_t t, input logic [4:0] row_max,
                                          input logic [4:0] col_max, input logic [6:0] ch_max);
    c1_tag_t n;
    n = t;
    if (t.ch == ch_max) begin
      n.ch = '0;
      if (t.col == col_max) begin
        n.col = '0;
        if (t.row != row_max) n.row = t.row + 5'd1;
      end else begin
        n.col = t.col + 5'd1;
      end
    end else begin
      n.ch = t.ch + 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/conv1_skid_fifo.sv
// Two-entry FIFO holding returned buffer data with its tags; head is read combinationally.
module conv1_skid_fifo #(
  parameter int PW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [PW-1:0] wdata,
  output logic [PW-1:0] rdata,
  output logic [1:0]    count
);
  logic [PW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  // A push into a full FIFO is only legal alongside a pop (the slot being freed).
  assign wr_en = push && ((count != 2'd2) || pop);
  assign rd_en = pop && (count != 2'd0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      count <= count + 2'(wr_en) - 2'(rd_en);
    end
  end

endmodule

// File: rtl/conv1_ofmap_streamer.sv
// Drains the conv1 output map from its buffer as a tagged valid/ready stream with a running checksum.
module conv1_ofmap_streamer
  import conv1_pkg::*;
#(
  parameter int H  = C1_OUT_H,
  parameter int W  = C1_OUT_W,
  parameter int C  = C1_OUT_C,
  parameter int DW = C1_DW,
  parameter int AW = $clog2(H*W*C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_row,
  output logic [4:0]    out_col,
  output logic [6:0]    out_ch,
  output logic          out_last,
  output logic [31:0]   checksum
);
  localparam int           PW      = DW + $bits(c1_tag_t);
  localparam logic [AW:0]  N_BEATS = (AW+1)'(H*W*C);
  localparam logic [4:0]   ROW_MAX = 5'(H-1);
  localparam logic [4:0]   COL_MAX = 5'(W-1);
  localparam logic [6:0]   CH_MAX  = 7'(C-1);

  c1_strm_state_e state_q, state_d;
  logic [AW:0]    issued;
  c1_tag_t        iss_tag, rd_tag, head_tag;
  logic           inflight, accept, pop;
  logic [1:0]     fifo_cnt;
  logic [2:0]     occ;
  logic [PW-1:0]  head;

  assign accept    = (state_q == IDLE) && start;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  // Occupancy counts the read in flight; a same-cycle pop frees one slot.
  assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign mem_rd_en = (state_q == RUN) && (issued < N_BEATS) && (occ < 3'd2);
  assign mem_rd_addr = issued[AW-1:0];

  assign head_tag  = c1_tag_t'(head[PW-1:DW]);
  assign out_data  = head[DW-1:0];
  assign out_row   = head_tag.row;
  assign out_col   = head_tag.col;
  assign out_ch    = head_tag.ch;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_last  = out_valid && (head_tag.row == ROW_MAX) &&
                     (head_tag.col == COL_MAX) && (head_tag.ch == CH_MAX);

  conv1_skid_fifo #(.PW(PW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .wdata ({rd_tag, mem_rd_data}),
    .rdata (head),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      issued   <= '0;
      iss_tag  <= '0;
      rd_tag   <= '0;
      inflight <= 1'b0;
      checksum <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= mem_rd_en;
      if (accept) begin
        issued   <= '0;
        iss_tag  <= '0;
        checksum <= '0;
      end else begin
        if (mem_rd_en) begin
          issued  <= issued + 1'b1;
          rd_tag  <= iss_tag;
          iss_tag <= c1_tag_next(iss_tag, ROW_MAX, COL_MAX, CH_MAX);
        end
        if (pop) checksum <= checksum + 32'(out_data);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv1_ofmap_streamer.sv
// Self-checking bench: small 2x2x3 build for protocol corners, default build for a full frame.
module tb_conv1_ofmap_streamer;
  localparam int SH = 2, SW = 2, SC = 3, SN = SH*SW*SC;
  localparam int BH = 27, BW = 27, BC = 96, BN = BH*BW*BC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // small build
  logic        s_start, s_busy, s_done, s_rd_en, s_valid, s_ready, s_last;
  logic [3:0]  s_rd_addr;
  logic [15:0] s_rd_data, s_data;
  logic [4:0]  s_row, s_col;
  logic [6:0]  s_ch;
  logic [31:0] s_cksum;

  conv1_ofmap_streamer #(.H(SH), .W(SW), .C(SC)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_row(s_row), .out_col(s_col), .out_ch(s_ch), .out_last(s_last), .checksum(s_cksum)
  );

  // default build
  logic        b_start, b_busy, b_done, b_rd_en, b_valid, b_ready, b_last;
  logic [16:0] b_rd_addr;
  logic [15:0] b_rd_data, b_data;
  logic [4:0]  b_row, b_col;
  logic [6:0]  b_ch;
  logic [31:0] b_cksum;

  conv1_ofmap_streamer dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .out_ch(b_ch), .out_last(b_last), .checksum(b_cksum)
  );

  // buffer models: one-cycle read latency, junk when not read
  always @(posedge clk) begin
    s_rd_data <= s_rd_en ? 16'(s_rd_addr) + 16'd1 : 16'hDEAD;
    b_rd_data <= b_rd_en ? b_rd_addr[15:0] : 16'hDEAD;
  end

  // small-build reference: beat i of a frame is buffer word i in raster order
  int          m_idx = 0, s_beats = 0, first_hs = 0, last_hs = 0, ovf_cnt = 0;
  logic [31:0] frame_sum = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_beat = '0;

  always @(negedge clk) begin
    if (dut_s.u_fifo.push && !dut_s.u_fifo.pop && dut_s.u_fifo.count == 2'd2)
      ovf_cnt <= ovf_cnt + 1;
    if (rst) begin
      m_idx      <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(s_valid), 32'd1);
        chk("hold_beat", {s_data, s_row, s_col, s_ch}, prev_beat[31:0]);
      end
      prev_stall <= s_valid && !s_ready;
      prev_beat  <= {8'd0, s_data, s_row, s_col, s_ch};
      if (s_valid && s_ready) begin
        chk("beat_data", 32'(s_data), 32'(m_idx + 1));
        chk("beat_tag", {s_row, s_col, s_ch},
            {5'(m_idx / (SW*SC)), 5'((m_idx / SC) % SW), 7'(m_idx % SC)});
        chk("beat_last", 32'(s_last), 32'(m_idx == SN-1));
        frame_sum <= ((m_idx == 0) ? 32'd0 : frame_sum) + 32'(s_data);
        if (m_idx == 0) first_hs <= cyc;
        last_hs <= cyc;
        s_beats <= s_beats + 1;
        m_idx   <= (m_idx == SN-1) ? 0 : m_idx + 1;
      end
    end
  end

  // default-build reference
  int          b_idx = 0, b_beats = 0;
  logic [31:0] b_sum = 0;
  logic [16:0] b_last_tag = '0;
  logic [15:0] b_last_data = '0;

  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      chk("big_data", 32'(b_data), 32'(b_idx[15:0]));
      chk("big_tag", {b_row, b_col, b_ch},
          {5'(b_idx / (BW*BC)), 5'((b_idx / BC) % BW), 7'(b_idx % BC)});
      chk("big_last", 32'(b_last), 32'(b_idx == BN-1));
      if (b_last) begin
        b_last_tag  <= {b_row, b_col, b_ch};
        b_last_data <= b_data;
      end
      b_sum   <= b_sum + 32'(b_data);
      b_beats <= b_beats + 1;
      b_idx   <= b_idx + 1;
    end
  end

  int done_cyc;

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (s_done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic frame_end(input string tn, input int base);
    bit ok;
    wait_done(400, ok);
    chk({tn, "_done"}, 32'(ok), 32'd1);
    chk({tn, "_beats"}, 32'(s_beats - base), 32'(SN));
    chk({tn, "_cksum"}, s_cksum, 32'd78);
    chk({tn, "_cksum_model"}, s_cksum, frame_sum);
  endtask

  initial begin
    int  base, nrd;
    bit  ok;
    rst = 1'b1; s_start = 1'b0; s_ready = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_rd_en", 32'(s_rd_en), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_last", 32'(s_last), 0);
    chk("rst_cksum", s_cksum, 0);
    chk("rst_addr", 32'(s_rd_addr), 0);
    chk("rst_big_valid", 32'(b_valid), 0);

    // ready held high: latency, back-to-back beats, done timing
    @(posedge clk); #1;
    s_ready = 1'b1;
    base = s_beats;
    pulse_start();
    @(negedge clk);
    chk("lat_rd_en", 32'(s_rd_en), 1);
    chk("lat_addr", 32'(s_rd_addr), 0);
    chk("lat_busy", 32'(s_busy), 1);
    @(negedge clk);
    chk("lat_valid_k2", 32'(s_valid), 0);
    @(negedge clk);
    chk("lat_valid_k3", 32'(s_valid), 1);
    chk("lat_first", 32'(s_data), 1);
    frame_end("t1", base);
    chk("t1_done_lag", 32'(done_cyc - last_hs), 1);
    chk("t1_span", 32'(last_hs - first_hs), 11);
    @(negedge clk);
    chk("t1_done_pulse", 32'(s_done), 0);

    // random backpressure
    @(posedge clk); #1;
    base = s_beats;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      s_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_done) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t3_done", 32'(ok), 1);
    chk("t3_beats", 32'(s_beats - base), 32'(SN));
    chk("t3_cksum", s_cksum, 32'd78);
    @(posedge clk); #1;
    s_ready = 1'b1;

    // start while busy, start in DONE, then a real restart
    base = s_beats;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_beats - base >= 5) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t4_reach5", 32'(ok), 1);
    pulse_start();
    frame_end("t4a", base);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    chk("t4_done_start_ign", 32'(s_busy), 0);
    chk("t4_cksum_hold", s_cksum, 32'd78);
    @(posedge clk); #1;
    base = s_beats;
    pulse_start();
    @(negedge clk);
    chk("t4_restart_busy", 32'(s_busy), 1);
    chk("t4_cksum_clr", s_cksum, 0);
    frame_end("t4b", base);

    // reset mid-frame
    @(posedge clk); #1;
    base = s_beats;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_beats - base >= 7) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t5_reach7", 32'(ok), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(s_busy), 0);
    chk("t5_rd_en", 32'(s_rd_en), 0);
    chk("t5_addr", 32'(s_rd_addr), 0);
    chk("t5_valid", 32'(s_valid), 0);
    chk("t5_last", 32'(s_last), 0);
    chk("t5_data", 32'(s_data), 0);
    chk("t5_tag", {s_row, s_col, s_ch}, 0);
    chk("t5_cksum", s_cksum, 0);
    ok = 1'b1;
    if (s_done) ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_done) ok = 1'b0;
    end
    chk("t5_no_done", 32'(ok), 1);
    @(posedge clk); #1;
    base = s_beats;
    pulse_start();
    @(negedge clk);
    chk("t5_replay_rd_en", 32'(s_rd_en), 1);
    chk("t5_replay_addr", 32'(s_rd_addr), 0);
    frame_end("t5", base);

    // downstream stalled at frame start
    @(posedge clk); #1;
    s_ready = 1'b0;
    base = s_beats;
    pulse_start();
    nrd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nrd += int'(s_rd_en);
    end
    chk("t6_reads", 32'(nrd), 2);
    chk("t6_rd_idle", 32'(s_rd_en), 0);
    chk("t6_valid_held", 32'(s_valid), 1);
    @(posedge clk); #1;
    s_ready = 1'b1;
    frame_end("t6", base);
    chk("t6_span", 32'(last_hs - first_hs), 11);
    chk("fifo_ovf", 32'(ovf_cnt), 0);

    // full-size frame
    @(posedge clk); #1;
    base = b_beats;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < BN + 200 && !ok; i++) begin
      @(negedge clk);
      if (b_done) ok = 1'b1;
    end
    chk("big_done", 32'(ok), 1);
    chk("big_beats", 32'(b_beats - base), 32'(BN));
    chk("big_cksum", b_cksum, b_sum);
    chk("big_final_tag", 32'(b_last_tag), {15'd0, 5'd26, 5'd26, 7'd95});
    chk("big_final_data", 32'(b_last_data), 32'h115F);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
